// File: rtl/mcm_poll_sched.sv
// Round-robin poll scheduler for MCM receive channels: per frame, request each enabled
// channel, wait for done or timeout, then guard gap. Optional retry-once: MCM_RETRY_EN.
`timescale 1ns/1ps
module mcm_poll_sched #(
  parameter int N_CH    = 4,
  parameter int SEL_W   = 2,
  parameter int RQ_LEN  = 4,
  parameter int TIMEOUT = 20000,
  parameter int TMR_W   = 15,
  parameter int GAP     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iStart,
  input  logic [N_CH-1:0]  iEnMask,
  input  logic [N_CH-1:0]  iDone,
  output logic [N_CH-1:0]  oRQ,
  output logic [SEL_W-1:0] oSel,
  output logic             oBusy,
  output logic             oFrameReady,
  output logic             oTimeout,
  output logic [N_CH-1:0]  oErrMask,
  output logic             oOverrun,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_GAP  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [TMR_W-1:0] RQ_LAST  = TMR_W'(RQ_LEN - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP - 1);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(N_CH - 1);

  state_t            state, state_nx;
  logic [SEL_W-1:0]  ch, ch_nx;
  logic [TMR_W-1:0]  cnt, cnt_nx;
  logic [N_CH-1:0]   en_lat, en_lat_nx;
  logic [N_CH-1:0]   err, err_nx;
  logic              timeout_nx, overrun_nx;
`ifdef MCM_RETRY_EN
  // retried: this channel already used its retry; again: go back to REQ after the gap
  logic              retried, retried_nx, again, again_nx;
`endif

  // Start handshake: iStart is accepted only in IDLE; any iStart seen while busy
  // (including the DONE cycle) is dropped and reported on oOverrun.
  always_comb begin
    state_nx   = state;
    ch_nx      = ch;
    cnt_nx     = cnt;
    en_lat_nx  = en_lat;
    err_nx     = err;
    timeout_nx = 1'b0;
    overrun_nx = iStart && (state != S_IDLE);
`ifdef MCM_RETRY_EN
    retried_nx = retried;
    again_nx   = again;
`endif
    case (state)
      S_IDLE: begin
        if (iStart) begin
          en_lat_nx = iEnMask;
          err_nx    = '0;
          ch_nx     = '0;
          cnt_nx    = '0;
          state_nx  = S_SCAN;
`ifdef MCM_RETRY_EN
          retried_nx = 1'b0;
          again_nx   = 1'b0;
`endif
        end
      end
      S_SCAN: begin
        cnt_nx = '0;
        if (en_lat[ch])         state_nx = S_REQ;
        else if (ch == CH_LAST) state_nx = S_DONE;
        else                    ch_nx    = ch + SEL_W'(1);
      end
      S_REQ: begin
        if (cnt == RQ_LAST) begin
          cnt_nx   = '0;
          state_nx = S_WAIT;
        end else begin
          cnt_nx = cnt + TMR_W'(1);
        end
      end
      S_WAIT: begin
        // done is checked first so it wins over a coinciding timeout
        if (iDone[ch]) begin
          cnt_nx   = '0;
          state_nx = S_GAP;
        end else if (cnt == TO_LAST) begin
          cnt_nx   = '0;
          state_nx = S_GAP;
`ifdef MCM_RETRY_EN
          if (!retried) begin
            retried_nx = 1'b1;
            again_nx   = 1'b1;
          end else begin
            err_nx[ch] = 1'b1;
            timeout_nx = 1'b1;
          end
`else
          err_nx[ch] = 1'b1;
          timeout_nx = 1'b1;
`endif
        end else if (cnt != '1) begin
          cnt_nx = cnt + TMR_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx = '0;
`ifdef MCM_RETRY_EN
          if (again) begin
            again_nx = 1'b0;
            state_nx = S_REQ;
          end else begin
            retried_nx = 1'b0;
            if (ch == CH_LAST) state_nx = S_DONE;
            else begin
              ch_nx    = ch + SEL_W'(1);
              state_nx = S_SCAN;
            end
          end
`else
          if (ch == CH_LAST) state_nx = S_DONE;
          else begin
            ch_nx    = ch + SEL_W'(1);
            state_nx = S_SCAN;
          end
`endif
        end else begin
          cnt_nx = cnt + TMR_W'(1);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ch          <= '0;
      cnt         <= '0;
      en_lat      <= '0;
      err         <= '0;
      oTimeout    <= 1'b0;
      oOverrun    <= 1'b0;
      oFrameReady <= 1'b0;
`ifdef MCM_RETRY_EN
      retried     <= 1'b0;
      again       <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      ch          <= ch_nx;
      cnt         <= cnt_nx;
      en_lat      <= en_lat_nx;
      err         <= err_nx;
      oTimeout    <= timeout_nx;
      oOverrun    <= overrun_nx;
      oFrameReady <= (state == S_DONE);
`ifdef MCM_RETRY_EN
      retried     <= retried_nx;
      again       <= again_nx;
`endif
    end
  end

  // Decoded straight from the state register so the strobe drops with async reset
  assign oRQ       = (state == S_REQ) ? (N_CH'(1) << ch) : '0;
  assign oSel      = ch;
  assign oBusy     = (state != S_IDLE);
  assign oErrMask  = err;
  assign dbg_state = state;

endmodule
